// File: rtl/bin2bcd_conv.sv
// bin2bcd_conv: sequential binary-to-BCD converter using shift-and-add-3, one bit per clock.
// Latches bin_in on start, runs BIN_W iterations, then loads bcd_out/ovf on the completion
// edge and holds them until the next completion. Digit 0 occupies bcd_out[3:0].
// Build option: define OVF_HEX_PASS_EN to show the raw operand (zero-extended) on overflow
// instead of saturating every digit to 9.
`timescale 1ns/1ps

module bin2bcd_conv #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  // Largest value representable in DIGITS decimal digits is 10^DIGITS - 1.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [63:0]      MAX_VAL  = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Shift register: BCD field on top, binary operand shifting out of the bottom.
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] ovf_sub;

  // Add-3 correction on every BCD nibble (top one included); binary part passes through.
  assign sr_adj[BIN_W-1:0] = sr_q[BIN_W-1:0];
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    assign sr_adj[BIN_W+4*gi +: 4] = (sr_q[BIN_W+4*gi +: 4] >= 4'd5)
                                   ? sr_q[BIN_W+4*gi +: 4] + 4'd3
                                   : sr_q[BIN_W+4*gi +: 4];
  end

  assign sr_shift = sr_adj << 1;

`ifdef OVF_HEX_PASS_EN
  // The shift register consumes the operand, so keep a copy for the raw-hex display.
  logic [BIN_W-1:0] bin_q, bin_d;

  // Overflow substitute: operand zero-extended to the display width.
  always_comb begin
    ovf_sub = '0;
    ovf_sub[BIN_W-1:0] = bin_q;
  end
`else
  // Overflow substitute: every digit saturates to 9.
  always_comb begin
    ovf_sub = {DIGITS{4'h9}};
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start is only honoured in IDLE; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CONV;
      S_CONV:  if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    busy = (state_q == S_CONV) || (state_q == S_DONE);
    done = (state_q == S_DONE);
  end

  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

  // Datapath next-state: latch on accept, iterate in CONV, publish on the last iteration.
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
`ifdef OVF_HEX_PASS_EN
    bin_d      = bin_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d              = '0;
          sr_d[BIN_W-1:0]   = bin_in;
          cnt_d             = CNT_INIT;
          ovf_pend_d        = (64'(bin_in) > MAX_VAL);
`ifdef OVF_HEX_PASS_EN
          bin_d             = bin_in;
`endif
        end
      end
      S_CONV: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          bcd_d = ovf_pend_q ? ovf_sub : sr_shift[SR_W-1:BIN_W];
          ovf_d = ovf_pend_q;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset clears everything so no partial result is ever visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
`ifdef OVF_HEX_PASS_EN
      bin_q      <= '0;
`endif
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
`ifdef OVF_HEX_PASS_EN
      bin_q      <= bin_d;
`endif
    end
  end

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Testbench for bin2bcd_conv: directed scenarios plus randomized operands, each result
// compared against a decimal-arithmetic reference model.
`timescale 1ns/1ps

module tb_bin2bcd_conv;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;
  localparam int BCD_W  = 4 * DIGITS;
  localparam longint unsigned MAX_DEC = 64'd99999999;

  logic             clk    = 1'b0;
  logic             rst    = 1'b0;
  logic             start  = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic [BCD_W-1:0] bcd_out;
  logic             busy;
  logic             done;
  logic             ovf;

  int vecs        = 0;
  int errs        = 0;
  int done_pulses = 0;

  bin2bcd_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // done is a one-cycle level, so one negedge sample per pulse.
  always @(negedge clk) if (rst && done === 1'b1) done_pulses++;

  // Reference: decimal digits by repeated division, or the overflow substitute.
  function automatic logic [BCD_W-1:0] model_bcd(input logic [BIN_W-1:0] v);
    longint unsigned x;
    logic [BCD_W-1:0] r;
    x = longint'(v);
    r = '0;
    if (x > MAX_DEC) begin
`ifdef OVF_HEX_PASS_EN
      r = BCD_W'(v);
`else
      r = {DIGITS{4'h9}};
`endif
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        r[4*i +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic model_ovf(input logic [BIN_W-1:0] v);
    return longint'(v) > MAX_DEC;
  endfunction

  // Drive one conversion and report what was observed (no checking here).
  task automatic run_conv(input logic [BIN_W-1:0] v,
                          output logic [BCD_W-1:0] o_bcd, output logic o_ovf,
                          output int o_lat, output bit o_early, output bit o_tail_ok);
    logic [BCD_W-1:0] prev;
    prev = bcd_out;
    @(negedge clk); bin_in = v; start = 1'b1;
    @(negedge clk); start = 1'b0; bin_in = BIN_W'($urandom);
    o_lat = 0; o_early = 1'b0;
    while (done !== 1'b1 && o_lat < 200) begin
      @(negedge clk);
      o_lat++;
      if (done !== 1'b1 && bcd_out !== prev) o_early = 1'b1;
    end
    o_bcd = bcd_out; o_ovf = ovf;
    @(negedge clk);
    o_tail_ok = (done === 1'b0) && (busy === 1'b0) && (bcd_out === o_bcd);
    $display("conv bin=%0d bcd=%h ovf=%b lat=%0d", v, o_bcd, o_ovf, o_lat);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vecs++; if (bcd_out !== '0) begin errs++; $display("FAIL reset_bcd: got %h expected 0", bcd_out); end
    vecs++; if ({busy, done, ovf} !== 3'b000) begin errs++; $display("FAIL reset_flags: got busy/done/ovf=%b expected 000", {busy, done, ovf}); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [BCD_W-1:0] b; logic o; int lat; bit early, tail;
    @(negedge clk); bin_in = BIN_W'(12345678); start = 1'b1;
    @(negedge clk); start = 1'b0;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL busy_after_start: got %b expected 1", busy); end
    repeat (BIN_W + 3) @(negedge clk);
    run_conv(BIN_W'(12345678), b, o, lat, early, tail);
    vecs++; if (b !== 32'h12345678) begin errs++; $display("FAIL basic_bcd: got %h expected 12345678", b); end
    vecs++; if (o !== 1'b0) begin errs++; $display("FAIL basic_ovf: got %b expected 0", o); end
    vecs++; if (lat != BIN_W) begin errs++; $display("FAIL basic_latency: got %0d expected %0d", lat, BIN_W); end
    vecs++; if (early) begin errs++; $display("FAIL basic_early_change: bcd_out moved before completion, expected hold"); end
    vecs++; if (!tail) begin errs++; $display("FAIL basic_done_pulse: done/busy/bcd after pulse wrong, got bcd=%h", bcd_out); end
    repeat (5) @(negedge clk);
    vecs++; if (bcd_out !== 32'h12345678) begin errs++; $display("FAIL basic_idle_hold: got %h expected 12345678", bcd_out); end
  endtask

  task automatic test_boundaries();
    logic [BIN_W-1:0] vals [4];
    logic [BCD_W-1:0] b; logic o; int lat; bit early, tail;
    vals[0] = '0; vals[1] = BIN_W'(99999999); vals[2] = BIN_W'(100000000); vals[3] = '1;
    for (int i = 0; i < 4; i++) begin
      run_conv(vals[i], b, o, lat, early, tail);
      vecs++; if (b !== model_bcd(vals[i])) begin errs++; $display("FAIL bound_bcd[%0d]: got %h expected %h", i, b, model_bcd(vals[i])); end
      vecs++; if (o !== model_ovf(vals[i])) begin errs++; $display("FAIL bound_ovf[%0d]: got %b expected %b", i, o, model_ovf(vals[i])); end
      vecs++; if (lat != BIN_W || early || !tail) begin errs++; $display("FAIL bound_timing[%0d]: got lat=%0d early=%0d tail=%0d expected %0d/0/1", i, lat, early, tail, BIN_W); end
    end
  endtask

  task automatic test_ignore_start();
    int p0, n;
    p0 = done_pulses;
    @(negedge clk); bin_in = BIN_W'(42); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    bin_in = BIN_W'(7); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    vecs++; if (bcd_out !== 32'h00000042 || ovf !== 1'b0) begin errs++; $display("FAIL ignore_bcd: got %h/%b expected 00000042/0", bcd_out, ovf); end
    repeat (BIN_W + 8) @(negedge clk);
    vecs++; if (done_pulses - p0 != 1) begin errs++; $display("FAIL ignore_pulses: got %0d expected 1", done_pulses - p0); end
    vecs++; if (bcd_out !== 32'h00000042 || busy !== 1'b0) begin errs++; $display("FAIL ignore_hold: got %h busy=%b expected 00000042 busy=0", bcd_out, busy); end
  endtask

  task automatic test_abort();
    logic [BCD_W-1:0] b; logic o; int lat; bit early, tail; int p0;
    vecs++; if (bcd_out !== 32'h00000042) begin errs++; $display("FAIL abort_pre: got %h expected 00000042", bcd_out); end
    p0 = done_pulses;
    @(negedge clk); bin_in = BIN_W'(555); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++; if (bcd_out !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin errs++; $display("FAIL abort_reset: got bcd=%h busy=%b done=%b ovf=%b expected 0/0/0/0", bcd_out, busy, done, ovf); end
    @(negedge clk); rst = 1'b1;
    vecs++; if (done_pulses != p0) begin errs++; $display("FAIL abort_pulse: got %0d pulses expected 0", done_pulses - p0); end
    run_conv(BIN_W'(555), b, o, lat, early, tail);
    vecs++; if (b !== 32'h00000555 || o !== 1'b0 || lat != BIN_W) begin errs++; $display("FAIL abort_rerun: got %h/%b lat=%0d expected 00000555/0 lat=%0d", b, o, lat, BIN_W); end
  endtask

  task automatic test_back_to_back();
    logic [BIN_W-1:0] v1, v2; int n;
    v1 = BIN_W'($urandom_range(0, 99999999));
    v2 = BIN_W'($urandom_range(0, 99999999));
    @(negedge clk); bin_in = v1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    // Request raised while DONE: ignored at that edge, accepted at the next (IDLE).
    bin_in = v2; start = 1'b1;
    vecs++; if (bcd_out !== model_bcd(v1)) begin errs++; $display("FAIL b2b_first: got %h expected %h", bcd_out, model_bcd(v1)); end
    @(negedge clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_done_ignore: got busy=%b expected 0", busy); end
    @(negedge clk); start = 1'b0; bin_in = v1 ^ BIN_W'(1);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    $display("conv bin=%0d bcd=%h ovf=%b lat=%0d", v2, bcd_out, ovf, n);
    vecs++; if (bcd_out !== model_bcd(v2) || n != BIN_W) begin errs++; $display("FAIL b2b_second: got %h lat=%0d expected %h lat=%0d", bcd_out, n, model_bcd(v2), BIN_W); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [BIN_W-1:0] v; logic [BCD_W-1:0] b; logic o; int lat; bit early, tail;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) v = BIN_W'($urandom);
      else v = BIN_W'($urandom_range(0, 99999999));
      run_conv(v, b, o, lat, early, tail);
      vecs++; if (b !== model_bcd(v) || o !== model_ovf(v)) begin errs++; $display("FAIL rand_result[%0d]: bin=%0d got %h/%b expected %h/%b", i, v, b, o, model_bcd(v), model_ovf(v)); end
      vecs++; if (lat != BIN_W || early || !tail) begin errs++; $display("FAIL rand_timing[%0d]: got lat=%0d early=%0d tail=%0d expected %0d/0/1", i, lat, early, tail, BIN_W); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
